l2_req_scheduler: RTL and testbench
===================================

// Module: l2_req_scheduler
// PURPOSE
//  Shares the single L2 cache port between three requesters: icache (read only),
//  dcache (read/write) and the next-line prefetcher (read only). Sits between the
//  L1 caches/prefetcher and L2. Grants round-robin, keeps one transaction in
//  flight, registers all L2-side outputs, and flags an L2 that stops responding.
// PARAMETERS
//  WIDTH           32    data width of the rdata/wdata buses
//  TIMEOUT_CYCLES  1024  BUSY cycles without L2 resp before timeout_err sets
// PORTS
//  clk               in   1      clock, all state on rising edge
//  rst               in   1      reset, asynchronous, active-high
//  icache_read       in   1      icache read request
//  icache_address    in   32     icache request address
//  icache_rdata      out  WIDTH  read data, = L2cache_rdata
//  icache_resp       out  1      icache transaction done, 1-cycle pulse
//  dcache_read       in   1      dcache read request
//  dcache_write      in   1      dcache write request
//  dcache_address    in   32     dcache request address
//  dcache_wdata      in   WIDTH  dcache write data
//  dcache_byte_enable in  4      dcache write byte enables
//  dcache_rdata      out  WIDTH  read data, = L2cache_rdata
//  dcache_resp       out  1      dcache transaction done, 1-cycle pulse
//  pf_read           in   1      prefetcher read request
//  pf_address        in   32     prefetcher request address
//  pf_resp           out  1      prefetch transaction done, 1-cycle pulse
//  L2cache_read      out  1      registered L2 read strobe
//  L2cache_write     out  1      registered L2 write strobe
//  L2cache_address   out  32     registered L2 address
//  L2cache_wdata     out  WIDTH  registered L2 write data
//  L2cache_byte_enable out 4     registered byte enables (4'hF on reads)
//  L2cache_rdata     in   WIDTH  L2 read data
//  L2cache_resp      in   1      L2 done, valid rdata on reads
//  timeout_err       out  1      sticky: watchdog expired
// BEHAVIOUR
//  Reset: state=IDLE, last=2 (icache wins first), all outputs 0, watchdog=0.
//  rst asserted at any time, including mid-BUSY, clears immediately with no clock.
//  Requester index: 0=icache, 1=dcache, 2=pf. Request = read|write.
//  dcache_read and dcache_write together: treat as write.
//  IDLE: if any request, choose first requester in order (last+1),(last+2),(last+3)
//   mod 3; at the edge latch grant, address, write, wdata, byte_enable
//   (4'hF for reads) into the L2 output registers; go BUSY. L2 strobe is
//   asserted the cycle after the request is first seen (1-cycle latency).
//  BUSY: L2 outputs held stable; requester input changes ignored.
//   On L2cache_resp: assert the granted <x>_resp combinationally in that cycle
//   (others 0). At the edge clear L2cache_read/write, set last=grant, go IDLE.
//   A requester that dropped its request in BUSY still gets its resp pulse.
//  One idle cycle between transactions minimum; requesters deassert the cycle
//   after resp, as the L1 caches do.
//  L2cache_resp in IDLE: ignored, no <x>_resp pulse.
//  Watchdog: cleared on IDLE->BUSY, +1 per BUSY cycle without resp, saturating.
//   When it reaches TIMEOUT_CYCLES, timeout_err=1. Transaction is not aborted.
//   Cleared only by rst.
//  pf has no write path; rdata outputs are unregistered passthroughs.
// TESTING
//  icache_read @0x60, resp 3 cycles later, rdata 0xDEADBEEF -> L2cache_read=1,
//   addr 0x60 from next cycle; icache_resp 1 cycle with rdata; L2cache_read=0 after.
//  After reset, all 3 request and re-request after each resp -> grant order
//   icache, dcache, pf, icache; no requester served twice while another waits.
//  dcache_write @0x1000, wdata 0xCAFEF00D, be 4'h3, L2 stalls 5 cycles -> write,
//   addr, wdata, be stable all 6 BUSY cycles; dcache_resp 1 pulse; icache_resp=0.
//  pf_read dropped 1 cycle after grant -> L2 transaction completes, pf_resp pulses.
//  TIMEOUT_CYCLES=8, no resp for 12 cycles -> timeout_err=1 after the 8th BUSY
//   cycle; later resp completes normally; timeout_err stays 1.
//  rst pulsed mid-BUSY between edges -> L2cache_read/write, resps, timeout_err
//   go 0 immediately; next grant is icache.

Source files
------------

// File: rtl/l2_req_scheduler.sv
// Round-robin arbiter sharing one L2 port among icache, dcache and the prefetcher.
// One transaction in flight; L2-side outputs registered; sticky watchdog on a silent L2.
module l2_req_scheduler #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_read,
  input  logic [31:0]      icache_address,
  output logic [WIDTH-1:0] icache_rdata,
  output logic             icache_resp,
  input  logic             dcache_read,
  input  logic             dcache_write,
  input  logic [31:0]      dcache_address,
  input  logic [WIDTH-1:0] dcache_wdata,
  input  logic [3:0]       dcache_byte_enable,
  output logic [WIDTH-1:0] dcache_rdata,
  output logic             dcache_resp,
  input  logic             pf_read,
  input  logic [31:0]      pf_address,
  output logic             pf_resp,
  output logic             L2cache_read,
  output logic             L2cache_write,
  output logic [31:0]      L2cache_address,
  output logic [WIDTH-1:0] L2cache_wdata,
  output logic [3:0]       L2cache_byte_enable,
  input  logic [WIDTH-1:0] L2cache_rdata,
  input  logic             L2cache_resp,
  output logic             timeout_err
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d, grant_q, grant_d;
  logic             rd_q, rd_d, wr_q, wr_d, to_q, to_d;
  logic [31:0]      addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [WDW-1:0]   wd_q, wd_d;

  logic [2:0] req;
  logic [1:0] pick, cand;
  logic       found;

  assign req = {pf_read, dcache_read | dcache_write, icache_read};

  // Scan requesters starting just after the last one served.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    cand  = last_q;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wd_d    = wd_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = pick;
          wd_d    = '0;
          // Simultaneous dcache read+write is serviced as a write.
          wr_d    = (pick == 2'd1) && dcache_write;
          rd_d    = !((pick == 2'd1) && dcache_write);
          unique case (pick)
            2'd0:    addr_d = icache_address;
            2'd1:    addr_d = dcache_address;
            default: addr_d = pf_address;
          endcase
          wdata_d = (pick == 2'd1) ? dcache_wdata : '0;
          be_d    = ((pick == 2'd1) && dcache_write) ? dcache_byte_enable : 4'hF;
        end
      end
      BUSY: begin
        if (L2cache_resp) begin
          state_d = IDLE;
          last_d  = grant_q;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
          if (wd_d == WD_MAX) to_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      grant_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  logic done;
  assign done = (state_q == BUSY) && L2cache_resp;

  assign icache_resp         = done && (grant_q == 2'd0);
  assign dcache_resp         = done && (grant_q == 2'd1);
  assign pf_resp             = done && (grant_q == 2'd2);
  assign icache_rdata        = L2cache_rdata;
  assign dcache_rdata        = L2cache_rdata;
  assign L2cache_read        = rd_q;
  assign L2cache_write       = wr_q;
  assign L2cache_address     = addr_q;
  assign L2cache_wdata       = wdata_q;
  assign L2cache_byte_enable = be_q;
  assign timeout_err         = to_q;
endmodule

// File: tb/tb_l2_req_scheduler.sv
// Randomized bench for l2_req_scheduler: a transaction-level model predicts every
// output each cycle; directed scenarios pin the model with literal expectations.
module tb_l2_req_scheduler;
  localparam int W  = 32;
  localparam int TO = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic icache_read = 0, dcache_read = 0, dcache_write = 0, pf_read = 0;
  logic [31:0] icache_address = 0, dcache_address = 0, pf_address = 0;
  logic [W-1:0] dcache_wdata = 0, L2cache_rdata = 0;
  logic [3:0] dcache_byte_enable = 0;
  logic L2cache_resp = 0;
  logic [W-1:0] icache_rdata, dcache_rdata, L2cache_wdata;
  logic icache_resp, dcache_resp, pf_resp, L2cache_read, L2cache_write, timeout_err;
  logic [31:0] L2cache_address;
  logic [3:0] L2cache_byte_enable;

  l2_req_scheduler #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_byte_enable(dcache_byte_enable), .dcache_rdata(dcache_rdata),
    .dcache_resp(dcache_resp), .pf_read(pf_read), .pf_address(pf_address),
    .pf_resp(pf_resp), .L2cache_read(L2cache_read), .L2cache_write(L2cache_write),
    .L2cache_address(L2cache_address), .L2cache_wdata(L2cache_wdata),
    .L2cache_byte_enable(L2cache_byte_enable), .L2cache_rdata(L2cache_rdata),
    .L2cache_resp(L2cache_resp), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Requester / L2 stimulus state
  bit          req_on [3];
  bit          cool   [3];
  bit          en     [3];
  logic [31:0] addr_r [3];
  bit          d_rd, d_wr;
  logic [W-1:0] wdata_r;
  logic [3:0]  be_r;
  int          p_req, lat_min, lat_max, stall_left;
  bit          rnd_mode;
  logic [W-1:0] fixed_rdata;

  // Transaction-level model
  bit          m_busy, m_rd, m_wr, m_to;
  int          m_grant, m_last, m_wd;
  logic [31:0] m_addr;
  logic [W-1:0] m_wdata;
  logic [3:0]  m_be;
  int          grants[$];
  int          cnt_resp[3];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_rd = 0; m_wr = 0; m_to = 0; m_grant = 0; m_last = 2; m_wd = 0;
    m_addr = 0; m_wdata = 0; m_be = 0; stall_left = 0;
    for (int i = 0; i < 3; i++) begin req_on[i] = 0; cool[i] = 0; end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 3; i++) begin
      if (en[i] && !req_on[i] && !cool[i] && !(m_busy && m_grant == i) &&
          $urandom_range(0, 99) < p_req) begin
        req_on[i] = 1;
        addr_r[i] = $urandom;
        if (i == 1) begin
          int t;
          t = $urandom_range(0, 2);
          d_wr = (t != 0);
          d_rd = (t != 1);
          wdata_r = $urandom;
          be_r = 4'($urandom);
        end
      end
      cool[i] = 0;
    end
    if (rnd_mode && m_busy && req_on[m_grant] && $urandom_range(0, 7) == 0)
      req_on[m_grant] = 0;
    icache_read = req_on[0];  icache_address = addr_r[0];
    dcache_read = req_on[1] && d_rd;  dcache_write = req_on[1] && d_wr;
    dcache_address = addr_r[1];  dcache_wdata = wdata_r;  dcache_byte_enable = be_r;
    pf_read = req_on[2];  pf_address = addr_r[2];
    if (m_busy) L2cache_resp = (stall_left == 0);
    else        L2cache_resp = rnd_mode && ($urandom_range(0, 7) == 0);
    L2cache_rdata = rnd_mode ? W'($urandom) : fixed_rdata;
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_outputs();
    logic [2:0] exp_resp;
    exp_resp = 3'b000;
    if (m_busy && L2cache_resp) exp_resp[m_grant] = 1'b1;
    chk("icache_resp", icache_resp, exp_resp[0]);
    chk("dcache_resp", dcache_resp, exp_resp[1]);
    chk("pf_resp", pf_resp, exp_resp[2]);
    chk("icache_rdata", icache_rdata, L2cache_rdata);
    chk("dcache_rdata", dcache_rdata, L2cache_rdata);
    chk("L2_read", L2cache_read, m_rd);
    chk("L2_write", L2cache_write, m_wr);
    chk("timeout_err", timeout_err, m_to);
    if (m_rd || m_wr) begin
      chk("L2_addr", L2cache_address, m_addr);
      chk("L2_be", L2cache_byte_enable, m_be);
    end
    if (m_wr) chk("L2_wdata", L2cache_wdata, m_wdata);
    if (icache_resp) cnt_resp[0]++;
    if (dcache_resp) cnt_resp[1]++;
    if (pf_resp)     cnt_resp[2]++;
  endtask

  task automatic model_update();
    logic [2:0] req;
    int idx;
    if (m_busy) begin
      if (L2cache_resp) begin
        m_busy = 0; m_last = m_grant; m_rd = 0; m_wr = 0;
        req_on[m_grant] = 0; cool[m_grant] = 1;
      end else begin
        if (m_wd < TO) m_wd++;
        if (m_wd >= TO) m_to = 1;
        if (stall_left > 0) stall_left--;
      end
    end else begin
      req = {pf_read, dcache_read | dcache_write, icache_read};
      idx = -1;
      for (int k = 1; k <= 3; k++)
        if (idx < 0 && req[(m_last + k) % 3]) idx = (m_last + k) % 3;
      if (idx >= 0) begin
        m_busy = 1; m_grant = idx; m_wd = 0;
        stall_left = $urandom_range(lat_min, lat_max);
        m_wr = (idx == 1) && dcache_write;
        m_rd = !m_wr;
        m_addr = (idx == 0) ? icache_address : (idx == 1) ? dcache_address : pf_address;
        m_be = m_wr ? dcache_byte_enable : 4'hF;
        m_wdata = dcache_wdata;
        grants.push_back(idx);
      end
    end
  endtask

  task automatic cycle();
    drive_inputs();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_ports();
    icache_read = 0; dcache_read = 0; dcache_write = 0; pf_read = 0; L2cache_resp = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_ports();
    model_reset();
    #3;
    chk("rst_L2_read", L2cache_read, 1'b0);
    chk("rst_L2_write", L2cache_write, 1'b0);
    chk("rst_L2_addr", L2cache_address, 32'h0);
    chk("rst_L2_be", L2cache_byte_enable, 4'h0);
    chk("rst_timeout", timeout_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    grants.delete();
    for (int i = 0; i < 3; i++) cnt_resp[i] = 0;
  endtask

  task automatic setup(input int p, input int lmin, input int lmax, input bit rnd);
    p_req = p; lat_min = lmin; lat_max = lmax; rnd_mode = rnd;
    for (int i = 0; i < 3; i++) en[i] = 1;
  endtask

  initial begin
    fixed_rdata = 0; d_rd = 0; d_wr = 0; wdata_r = 0; be_r = 0;
    for (int i = 0; i < 3; i++) addr_r[i] = 0;
    setup(0, 0, 0, 0);
    @(negedge clk);

    // icache read @0x60, answered in the 3rd BUSY cycle
    do_reset();
    setup(0, 2, 2, 0);
    fixed_rdata = 32'hDEADBEEF;
    req_on[0] = 1; addr_r[0] = 32'h60;
    cycle();
    chk("t1_L2_read", L2cache_read, 1'b1);
    chk("t1_L2_addr", L2cache_address, 32'h60);
    cycle(); cycle();
    drive_inputs(); #1;
    chk("t1_icache_resp", icache_resp, 1'b1);
    chk("t1_icache_rdata", icache_rdata, 32'hDEADBEEF);
    check_outputs();
    @(posedge clk); model_update(); @(negedge clk);
    chk("t1_L2_read_after", L2cache_read, 1'b0);
    chk("t1_resp_count", cnt_resp[0], 1);

    // Round-robin order with all three requesting and re-requesting
    do_reset();
    setup(100, 0, 0, 0);
    for (int c = 0; c < 40 && grants.size() < 4; c++) cycle();
    chk("t2_ngrants", grants.size(), 4);
    if (grants.size() >= 4) begin
      chk("t2_g0", grants[0], 0);
      chk("t2_g1", grants[1], 1);
      chk("t2_g2", grants[2], 2);
      chk("t2_g3", grants[3], 0);
    end
    p_req = 0;
    for (int c = 0; c < 10 && m_busy; c++) cycle();

    // dcache write with a 5-cycle L2 stall
    do_reset();
    setup(0, 5, 5, 0);
    req_on[1] = 1; d_wr = 1; d_rd = 0; addr_r[1] = 32'h1000;
    wdata_r = 32'hCAFEF00D; be_r = 4'h3;
    cycle();
    for (int k = 0; k < 6; k++) begin
      chk("t3_write", L2cache_write, 1'b1);
      chk("t3_addr", L2cache_address, 32'h1000);
      chk("t3_wdata", L2cache_wdata, 32'hCAFEF00D);
      chk("t3_be", L2cache_byte_enable, 4'h3);
      cycle();
    end
    chk("t3_dresp", cnt_resp[1], 1);
    chk("t3_iresp", cnt_resp[0], 0);
    chk("t3_write_after", L2cache_write, 1'b0);

    // pf drops its request one cycle after the grant
    do_reset();
    setup(0, 3, 3, 0);
    req_on[2] = 1; addr_r[2] = 32'h2040;
    cycle();
    cycle();
    req_on[2] = 0;
    repeat (3) cycle();
    chk("t4_pf_resp", cnt_resp[2], 1);
    chk("t4_L2_read_after", L2cache_read, 1'b0);

    // Watchdog: 12 silent BUSY cycles, then completion
    do_reset();
    setup(0, 12, 12, 0);
    req_on[0] = 1; addr_r[0] = 32'h80;
    cycle();
    for (int k = 1; k <= 13; k++) begin
      chk("t5_timeout", timeout_err, (k >= 9) ? 1'b1 : 1'b0);
      cycle();
    end
    chk("t5_iresp", cnt_resp[0], 1);
    chk("t5_sticky", timeout_err, 1'b1);
    chk("t5_L2_read_after", L2cache_read, 1'b0);

    // Reset pulsed mid-BUSY, after a dcache grant moved the pointer
    do_reset();
    setup(0, 0, 0, 0);
    req_on[1] = 1; d_rd = 1; d_wr = 0; addr_r[1] = 32'h300;
    repeat (3) cycle();
    lat_min = 20; lat_max = 20;
    req_on[2] = 1; addr_r[2] = 32'h400;
    repeat (11) cycle();
    chk("t6_busy_timeout", timeout_err, 1'b1);
    L2cache_resp = 1;
    #2 rst = 1;
    #1;
    chk("t6_rst_read", L2cache_read, 1'b0);
    chk("t6_rst_pf_resp", pf_resp, 1'b0);
    chk("t6_rst_timeout", timeout_err, 1'b0);
    @(negedge clk);
    do_reset();
    setup(100, 0, 0, 0);
    for (int c = 0; c < 5 && grants.size() < 1; c++) cycle();
    chk("t6_ngrants", grants.size(), 1);
    if (grants.size() >= 1) chk("t6_first_grant", grants[0], 0);

    // Randomized traffic, short latencies
    do_reset();
    setup(40, 0, 4, 1);
    repeat (3000) cycle();

    // Randomized traffic with latencies long enough to trip the watchdog
    do_reset();
    setup(60, 0, 11, 1);
    repeat (1500) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
